number_entry: RTL and testbench

NUMBER_ENTRY -- requirements
Module: number_entry

---
 rtl/cont_internal.sv | 10 +
 rtl/cpu_internal.sv | 4 +
 rtl/bcd_mac10.sv | 21 ++
 rtl/number_entry.sv | 171 +++++++++++++++++
 tb/tb_number_entry.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cont_internal.sv
// Shared controller-side types and defaults for the keypad/number-entry path.
package cont_internal;
  typedef enum logic [1:0] {
    NE_ENTRY = 2'd0,
    NE_CONV  = 2'd1,
    NE_OUT   = 2'd2
  } ne_state_t;

  localparam int unsigned ND_DEFAULT = 8;
endpackage

// File: rtl/cpu_internal.sv
// Shared datapath constants for the CPU-side blocks.
package cpu_internal;
  localparam int unsigned CD_N = 32;
endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + d step with saturation at the largest positive signed value.
module bcd_mac10 #(
  parameter int unsigned NW = 32
) (
  input  logic [NW-1:0] acc,
  input  logic [3:0]    d,
  output logic [NW-1:0] res,
  output logic          ovf
);
  localparam int unsigned WW = NW + 4;
  localparam logic [WW-1:0] MAXW = {{5{1'b0}}, {(NW-1){1'b1}}};

  logic [WW-1:0] prod;

  // acc never exceeds MAXW, so acc*10+9 always fits in WW bits
  always_comb begin
    prod = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{NW{1'b0}}, d};
    ovf  = (prod > MAXW);
    res  = ovf ? MAXW[NW-1:0] : prod[NW-1:0];
  end
endmodule

// File: rtl/number_entry.sv
// Keypad number entry: collects BCD digits and a sign, then converts MSD-first
// to a signed binary value presented with a valid/ready handshake.
module number_entry
  import cont_internal::*;
  import cpu_internal::*;
#(
  parameter int unsigned ND = ND_DEFAULT,
  parameter int unsigned NW = CD_N
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [3:0]      digit_D,
  input  logic            digit_EN,
  input  logic            bs_EN,
  input  logic            neg_EN,
  input  logic            clr_EN,
  input  logic            commit_EN,
  output logic [NW-1:0]   num_D,
  output logic            num_valid,
  input  logic            num_ready,
  output logic            num_ovf,
  output logic            busy,
  output logic [4*ND-1:0] disp_bcd,
  output logic [3:0]      disp_cnt,
  output logic            disp_neg
);
  localparam int unsigned BW     = 4 * ND;
  localparam logic [3:0]  ND_CNT = 4'(ND);

  ne_state_t       state_q, state_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [NW-1:0]   acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      idx_q, idx_d;
  logic [NW-1:0]   num_q, num_d;
  logic            nvalid_q, nvalid_d;
  logic            novf_q, novf_d;

  logic [3:0]      dsel;
  logic [NW-1:0]   mac_res;
  logic            mac_ovf;

  assign dsel = 4'(bcd_q >> {idx_q, 2'b00});

  bcd_mac10 #(.NW(NW)) u_mac (
    .acc (acc_q),
    .d   (dsel),
    .res (mac_res),
    .ovf (mac_ovf)
  );

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= NE_ENTRY;
      bcd_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
      num_q    <= '0;
      nvalid_q <= 1'b0;
      novf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      nvalid_q <= nvalid_d;
      novf_q   <= novf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    num_d    = num_q;
    nvalid_d = nvalid_q;
    novf_d   = novf_q;

    case (state_q)
      NE_ENTRY: begin
        if (commit_EN) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          idx_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          state_d = NE_CONV;
        end else if (bs_EN) begin
          if (cnt_q != 4'd0) begin
            bcd_d = bcd_q >> 4;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) neg_d = 1'b0;
          end
        end else if (neg_EN) begin
          neg_d = ~neg_q;
        end else if (digit_EN) begin
          // Leading zeros, non-BCD codes and a full buffer are all dropped
          if (digit_D <= 4'd9 && cnt_q < ND_CNT &&
              !(cnt_q == 4'd0 && digit_D == 4'd0)) begin
            bcd_d = (bcd_q << 4) | BW'(digit_D);
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      NE_CONV: begin
        acc_d = mac_res;
        ovf_d = ovf_q | mac_ovf;
        if (idx_q == 4'd0) begin
          state_d  = NE_OUT;
          nvalid_d = 1'b1;
          novf_d   = ovf_q | mac_ovf;
          num_d    = neg_q ? (~mac_res + NW'(1)) : mac_res;
        end else begin
          idx_d = idx_q - 4'd1;
        end
      end
      NE_OUT: begin
        if (nvalid_q && num_ready) begin
          state_d  = NE_ENTRY;
          bcd_d    = '0;
          cnt_d    = '0;
          neg_d    = 1'b0;
          acc_d    = '0;
          ovf_d    = 1'b0;
          num_d    = '0;
          nvalid_d = 1'b0;
          novf_d   = 1'b0;
        end
      end
      default: state_d = NE_ENTRY;
    endcase

    // Clear overrides every state and strobe
    if (clr_EN) begin
      state_d  = NE_ENTRY;
      bcd_d    = '0;
      cnt_d    = '0;
      neg_d    = 1'b0;
      acc_d    = '0;
      ovf_d    = 1'b0;
      idx_d    = '0;
      num_d    = '0;
      nvalid_d = 1'b0;
      novf_d   = 1'b0;
    end
  end

  // Outputs straight from registered state
  always_comb begin
    busy      = (state_q != NE_ENTRY);
    num_D     = num_q;
    num_valid = nvalid_q;
    num_ovf   = novf_q;
    disp_bcd  = bcd_q;
    disp_cnt  = cnt_q;
    disp_neg  = neg_q;
  end
endmodule

// File: tb/tb_number_entry.sv
// Scoreboard bench for number_entry: randomized keypad strobes against a digit-queue model.
module tb_number_entry;
  localparam int unsigned ND = 8;
  localparam int unsigned NW = 16;
  localparam longint      MAXV = (64'sd1 <<< (NW - 1)) - 1;

  logic            Clock = 1'b0;
  logic            Reset;
  logic [3:0]      digit_D;
  logic            digit_EN, bs_EN, neg_EN, clr_EN, commit_EN;
  logic [NW-1:0]   num_D;
  logic            num_valid, num_ready, num_ovf, busy;
  logic [4*ND-1:0] disp_bcd;
  logic [3:0]      disp_cnt;
  logic            disp_neg;

  always #5 Clock = ~Clock;

  number_entry #(.ND(ND), .NW(NW)) dut (
    .Clock(Clock), .Reset(Reset), .digit_D(digit_D), .digit_EN(digit_EN),
    .bs_EN(bs_EN), .neg_EN(neg_EN), .clr_EN(clr_EN), .commit_EN(commit_EN),
    .num_D(num_D), .num_valid(num_valid), .num_ready(num_ready), .num_ovf(num_ovf),
    .busy(busy), .disp_bcd(disp_bcd), .disp_cnt(disp_cnt), .disp_neg(disp_neg)
  );

  typedef struct {
    logic [NW-1:0] val;
    bit            ovf;
    int            lat;
    int            ccyc;
  } exp_t;

  exp_t sb[$];
  int   digs[$];
  bit   mneg;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a list of decimal digits and a sign flag
  function automatic void model_clear();
    digs.delete();
    mneg = 1'b0;
  endfunction

  function automatic void model_digit(input int d);
    if (d <= 9 && digs.size() < int'(ND) && !(digs.size() == 0 && d == 0))
      digs.push_back(d);
  endfunction

  function automatic void model_bs();
    if (digs.size() > 0) begin
      void'(digs.pop_back());
      if (digs.size() == 0) mneg = 1'b0;
    end
  endfunction

  function automatic void model_commit(input int c0);
    exp_t   e;
    longint v = 0;
    bit     o = 1'b0;
    foreach (digs[i]) begin
      v = v * 10 + digs[i];
      if (v > MAXV) begin
        v = MAXV;
        o = 1'b1;
      end
    end
    if (mneg) v = -v;
    e.val  = NW'(v);
    e.ovf  = o;
    e.lat  = ((digs.size() > 0) ? digs.size() : 1) + 1;
    e.ccyc = c0;
    sb.push_back(e);
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard head
  exp_t cur;
  bit   seen = 1'b0;
  always @(negedge Clock) begin
    if (Reset) begin
      seen = 1'b0;
    end else if (!num_valid) begin
      seen = 1'b0;
      chk("num_D_idle_zero", num_D, 0);
    end else begin
      if (!seen) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", num_valid, 0);
        end else begin
          cur  = sb.pop_front();
          seen = 1'b1;
          chk("num_D", num_D, cur.val);
          chk("num_ovf", num_ovf, cur.ovf);
          chk("latency", cyc - cur.ccyc, cur.lat);
          chk("busy_in_out", busy, 1);
        end
      end else begin
        chk("hold_num_D", num_D, cur.val);
        chk("hold_num_ovf", num_ovf, cur.ovf);
      end
      if (num_ready) seen = 1'b0;
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_strobes();
    digit_EN = 0; bs_EN = 0; neg_EN = 0; clr_EN = 0; commit_EN = 0;
  endtask

  task automatic check_disp(input string tag);
    logic [4*ND-1:0] e = '0;
    foreach (digs[i]) e = (e << 4) | (4*ND)'(digs[i]);
    chk({tag, "_disp_cnt"}, disp_cnt, digs.size());
    chk({tag, "_disp_neg"}, disp_neg, mneg);
    chk({tag, "_disp_bcd"}, disp_bcd, e);
  endtask

  // One strobe cycle; the model resolves simultaneous strobes by priority
  task automatic drive(input bit c, input bit cm, input bit b, input bit n,
                       input bit dg, input logic [3:0] d);
    int c0 = cyc;
    clr_EN = c; commit_EN = cm; bs_EN = b; neg_EN = n; digit_EN = dg; digit_D = d;
    step();
    clear_strobes();
    if (c) model_clear();
    else if (cm) model_commit(c0);
    else if (b) model_bs();
    else if (n) mneg = ~mneg;
    else if (dg) model_digit(int'(d));
  endtask

  task automatic key(input int d);
    drive(0, 0, 0, 0, 1, 4'(d));
    check_disp("key");
  endtask

  // Commit and wait for the handshake; mode 0 random ready + ignored strobes,
  // mode 1 ready held high, mode 2 ready held low for a while first
  task automatic run_txn(input int mode);
    int k = 0;
    drive(0, 1, 0, 0, 0, 4'd0);
    while (busy && k < 80) begin
      num_ready = (mode == 1) ? 1'b1 : (mode == 2) ? (k >= 14) : 1'($urandom_range(0, 1));
      if (mode == 0) begin
        digit_EN = 1'($urandom_range(0, 1)); bs_EN = 1'($urandom_range(0, 1));
        neg_EN = 1'($urandom_range(0, 1)); commit_EN = 1'($urandom_range(0, 1));
        digit_D = 4'($urandom_range(1, 9));
      end
      step();
      clear_strobes();
      k++;
      if (busy) check_disp("frozen");
    end
    chk("txn_done_busy", busy, 0);
    num_ready = 1'b0;
    model_clear();
    check_disp("after_txn");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    Reset = 1'b1; num_ready = 1'b0; digit_D = 4'd0;
    clear_strobes();
    model_clear();
    step(); step();
    chk("rst_num_D", num_D, 0);
    chk("rst_num_valid", num_valid, 0);
    chk("rst_num_ovf", num_ovf, 0);
    chk("rst_busy", busy, 0);
    check_disp("rst");
    Reset = 1'b0;
    step();

    // 1,2,3 -> 123 with four-cycle latency
    key(1); key(2); key(3);
    run_txn(1);

    // Leading zeros dropped, negative result
    key(0); key(0); key(5);
    drive(0, 0, 0, 1, 0, 4'd0);
    check_disp("neg");
    run_txn(1);

    // Backspace past empty gives 0 in two cycles
    key(7); key(8);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 4'd0);
      check_disp("bs");
    end
    run_txn(1);

    // Saturation with a stalled consumer
    key(4); key(0); key(0); key(0); key(0);
    run_txn(2);

    // Nine digits into an eight-digit buffer, plus non-BCD codes
    for (int i = 1; i <= 9; i++) key(i);
    key(10); key(15);
    run_txn(0);

    // Clear wins over a same-cycle digit, and aborts a conversion
    key(3);
    drive(1, 0, 0, 0, 1, 4'd6);
    check_disp("clr_prio");
    key(1); key(2); key(3); key(4); key(5);
    commit_EN = 1'b1; step(); clear_strobes();
    chk("conv_busy", busy, 1);
    drive(1, 0, 0, 0, 0, 4'd0);
    chk("clr_conv_busy", busy, 0);
    chk("clr_conv_valid", num_valid, 0);
    check_disp("clr_conv");
    repeat (8) step();
    chk("clr_conv_still_idle", num_valid, 0);

    // Reset while a result is held in OUT
    key(5);
    drive(0, 1, 0, 0, 0, 4'd0);
    k = 0;
    while (!num_valid && k < 20) begin step(); k++; end
    chk("out_reached", num_valid, 1);
    repeat (2) step();
    Reset = 1'b1; step(); Reset = 1'b0;
    model_clear();
    chk("rst_out_num_D", num_D, 0);
    chk("rst_out_valid", num_valid, 0);
    chk("rst_out_ovf", num_ovf, 0);
    chk("rst_out_busy", busy, 0);
    check_disp("rst_out");

    // Randomized entry sessions
    for (int t = 0; t < 30; t++) begin
      int nops = $urandom_range(0, 11);
      for (int j = 0; j < nops; j++) begin
        int r = $urandom_range(0, 9);
        if (r <= 5) drive(0, 0, 0, 0, 1, 4'($urandom_range(0, 11)));
        else if (r == 6) drive(0, 0, 1, 0, 0, 4'd0);
        else if (r == 7) drive(0, 0, 0, 1, 0, 4'd0);
        else if (r == 8) drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
        else drive(1, 0, 0, 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
        check_disp("rand");
      end
      run_txn(0);
    end

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
